shift_add_multiplier: RTL and testbench

- Sequential unsigned multiply-accumulate unit: result = multiplicand * multiplier + addend.
- Inverse of the team's iterative divider. Feeding it quotient, divisor and remainder reconstructs the dividend, so it serves as both a datapath multiplier and a divide-result checker.
- Uses the same start/done handshake and three-state control as the divider, so the two blocks are drop-in peers on a shared controller.

---
 rtl/shift_add_multiplier.sv | 154 +++++++++++++++
 tb/tb_shift_add_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned multiply-accumulate unit:
//     result = multiplicand * multiplier + addend
// This is the inverse of the iterative divider. If you feed it quotient,
// divisor and remainder, it gives back the dividend. It uses the same
// start/done handshake and the same IDLE/MULTIPLYING/DONE control, so the two
// blocks can sit side by side on one controller.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request; level-sampled in IDLE, hold until done is seen
//   multiplicand operand A (unsigned), latched on accept
//   multiplier   operand B (unsigned), latched on accept
//   addend       added to the product (unsigned), latched on accept
//   result       registered A*B+addend (2*WIDTH bits)
//   overflow     result does not fit in WIDTH bits
//   busy         high while multiplying
//   done         completion flag, held until start drops
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] result,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MULTIPLYING = 2'd1,
        DONE        = 2'd2
    } state_t;

    state_t             state_reg,    state_next;
    logic [2*WIDTH-1:0] acc_reg,      acc_next;
    logic [2*WIDTH-1:0] mcand_reg,    mcand_next;
    logic [WIDTH-1:0]   mplier_reg,   mplier_next;
    logic [CW-1:0]      count_reg,    count_next;
    logic [2*WIDTH-1:0] result_reg,   result_next;
    logic               overflow_reg, overflow_next;
    logic               done_reg,     done_next;

    // Accumulator value after this cycle's conditional add. It is 2*WIDTH
    // bits wide, and the largest possible final value (2^2W - 2^W) fits, so
    // it never wraps.
    logic [2*WIDTH-1:0] acc_sum;
    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // State register plus all datapath registers. The reset is asynchronous,
    // so an in-flight operation is dropped at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            count_reg    <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            mcand_reg    <= mcand_next;
            mplier_reg   <= mplier_next;
            count_reg    <= count_next;
            result_reg   <= result_next;
            overflow_reg <= overflow_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        mcand_next    = mcand_reg;
        mplier_next   = mplier_reg;
        count_next    = count_reg;
        result_next   = result_reg;
        overflow_next = overflow_reg;
        done_next     = done_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (multiplicand == '0 || multiplier == '0) begin
                        // A zero product needs no iterations. The answer is
                        // just the addend.
                        result_next   = {{WIDTH{1'b0}}, addend};
                        overflow_next = 1'b0;
                        done_next     = 1'b1;
                        state_next    = DONE;
                    end else begin
                        acc_next      = {{WIDTH{1'b0}}, addend};
                        mcand_next    = {{WIDTH{1'b0}}, multiplicand};
                        mplier_next   = multiplier;
                        count_next    = '0;
                        result_next   = '0;
                        overflow_next = 1'b0;
                        done_next     = 1'b0;
                        state_next    = MULTIPLYING;
                    end
                end
            end

            MULTIPLYING: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + 1'b1;
                // Latency is fixed at WIDTH iterations. There is no early
                // exit when the multiplier runs out of set bits.
                if (count_reg == LAST_COUNT) begin
                    result_next   = acc_sum;
                    overflow_next = |acc_sum[2*WIDTH-1:WIDTH];
                    done_next     = 1'b1;
                    state_next    = DONE;
                end
            end

            DONE: begin
                // Stay here while start is held, so a held request cannot
                // retrigger a second operation.
                if (!start) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign done     = done_reg;
    assign busy     = (state_reg == MULTIPLYING);

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   addend = '0;
    logic [2*W-1:0] result;
    logic           overflow;
    logic           busy;
    logic           done;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .result       (result),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic           ovf;
        int             lat;
        int             busy_n;
        int             acc_cycle;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   checks = 0;
    int   passes = 0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Monitor: it pops one expected entry on every rising edge of done.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
            done_prev = 1'b0;
        end else begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    check_int("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check64("result", result, e.res);
                    check_int("overflow", int'(overflow), int'(e.ovf));
                    check_int("latency", cycle - e.acc_cycle, e.lat);
                    check_int("busy_cycles", busy_cnt, e.busy_n);
                    $display("op done: result=0x%016h ovf=%0b cycle=%0d", result, overflow, cycle);
                end
                busy_cnt = 0;
            end
            done_prev = done;
        end
    end

    // Reference model: plain unsigned arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        exp_t e;
        longint unsigned p;
        p = longint'(a) * longint'(b) + longint'(c);
        e.res = p;
        e.ovf = (p >> W) != 0;
        e.lat = (a == 0 || b == 0) ? 0 : W;
        e.busy_n = (a == 0 || b == 0) ? 0 : W;
        e.acc_cycle = 0;
        return e;
    endfunction

    // hold: extra cycles to keep start high in DONE. perturb: change the
    // operands and drop start partway through the operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input int hold, input bit perturb);
        exp_t e;
        bit   seen;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        e = model(a, b, c);
        e.acc_cycle = cycle + 1;
        sb.push_back(e);
        if (perturb) begin
            repeat (10) @(negedge clk);
            multiplicand = $urandom;
            multiplier   = $urandom;
            addend       = $urandom;
            start        = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            check_int("done_timeout", 0, 1);
            start = 1'b0;
            sb.delete();
            repeat (3) @(negedge clk);
            return;
        end
        if (!perturb) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_int("done_held", int'(done), 1);
                check_int("no_retrigger_busy", int'(busy), 0);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check_int("done_dropped", int'(done), 0);
        check64("result_holds", result, e.res);
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        repeat (2) @(negedge clk);
        check64("reset_result", result, '0);
        check_int("reset_flags", int'({overflow, busy, done}), 0);
        reset_n = 1'b1;

        run_op(32'd5, 32'd4, 32'd0, 0, 1'b0);
        run_op(32'd3, 32'd5, 32'd2, 0, 1'b0);
        run_op(32'd10, 32'd10, 32'd0, 0, 1'b0);
        run_op(32'd0, 32'd7, 32'd9, 0, 1'b0);
        run_op(32'd7, 32'd0, 32'd9, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 0, 1'b0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        multiplicand = 32'd1234; multiplier = 32'd5678; addend = 32'd1; start = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check64("async_reset_result", result, '0);
        check_int("async_reset_flags", int'({overflow, busy, done}), 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd1234, 32'd5678, 32'd1, 0, 1'b0);

        // Operands change and start drops mid-operation. Later, start is
        // held high through DONE.
        run_op(32'd1000, 32'd3000, 32'd7, 0, 1'b1);
        run_op(32'd99, 32'd77, 32'd5, 5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom; b = $urandom; c = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '0;
                2: begin a = a & 32'hFF; b = b & 32'hFF; end
                default: ;
            endcase
            run_op(a, b, c, $urandom_range(0, 2), ($urandom_range(0, 5) == 0) && a != 0 && b != 0);
        end

        repeat (3) @(negedge clk);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
